// File: rtl/mux_reg_pkg.sv
// Shared constants and types for the mux_reg_8x8 register bank.
package mux_reg_pkg;

  localparam int unsigned MUX_REG_WIDTH = 8;
  localparam int unsigned MUX_REG_DEPTH = 8;

  typedef logic [MUX_REG_WIDTH-1:0] mux_data_t;
  typedef logic [MUX_REG_DEPTH-1:0] mux_sel_t;

endpackage

// File: rtl/mux_reg_entry.sv
// One WIDTH-bit register with load enable, async active-low clear and a serial
// scan path (scan_in enters bit 0, scan_out leaves from bit WIDTH-1).
module mux_reg_entry #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic [WIDTH-1:0] q,
  output logic             scan_out
);

  logic [WIDTH-1:0] shift_d;

  assign shift_d  = (q << 1) | WIDTH'(scan_in);
  assign scan_out = q[WIDTH-1];

  // Shift takes priority over a functional load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (scan_en) begin
      q <= shift_d;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mux_reg_8x8.sv
// Bank of DEPTH one-hot-written registers with an AND-OR read mux.
// Define MUX_REG_SCAN_EN to build the serial scan chain (tc/td/tq).
module mux_reg_8x8
  import mux_reg_pkg::*;
#(
  parameter int unsigned WIDTH = MUX_REG_WIDTH,
  parameter int unsigned DEPTH = MUX_REG_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [DEPTH-1:0] en_in,
  input  logic [DEPTH-1:0] en_out,
  output logic [WIDTH-1:0] out,
  input  logic             tc,
  input  logic             td,
  output logic             tq
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH:0]   chain;
  logic             scan_en;

`ifdef MUX_REG_SCAN_EN
  assign scan_en  = tc;
  assign chain[0] = td;
  assign tq       = chain[DEPTH];
`else
  logic unused_scan;

  assign scan_en     = 1'b0;
  assign chain[0]    = 1'b0;
  assign tq          = 1'b0;
  assign unused_scan = ^{tc, td, chain[DEPTH]};
`endif

  for (genvar k = 0; k < DEPTH; k++) begin : g_entry
    mux_reg_entry #(
      .WIDTH (WIDTH)
    ) u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (en_in[k]),
      .d        (in),
      .scan_en  (scan_en),
      .scan_in  (chain[k]),
      .q        (regs[k]),
      .scan_out (chain[k+1])
    );
  end

  // Multiple select bits OR the chosen registers together.
  always_comb begin
    out = '0;
    for (int k = 0; k < DEPTH; k++) begin
      out = out | (regs[k] & {WIDTH{en_out[k]}});
    end
  end

endmodule

// File: tb/tb_mux_reg_8x8.sv
// Self-checking bench for mux_reg_8x8: directed cases plus randomized traffic
// compared against an array-based reference model.
module tb_mux_reg_8x8;
  import mux_reg_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n;
  mux_data_t in;
  mux_sel_t  en_in;
  mux_sel_t  en_out;
  mux_data_t out;
  logic      tc;
  logic      td;
  logic      tq;

  int n_checks = 0;
  int n_errors = 0;

  mux_data_t mdl [8];

`ifdef MUX_REG_SCAN_EN
  localparam bit ScanBuild = 1'b1;
`else
  localparam bit ScanBuild = 1'b0;
`endif

  mux_reg_8x8 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (in),
    .en_in  (en_in),
    .en_out (en_out),
    .out    (out),
    .tc     (tc),
    .td     (td),
    .tq     (tq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic mux_data_t mdl_read(input mux_sel_t sel);
    mux_data_t r = '0;
    for (int k = 0; k < 8; k++) if (sel[k]) r |= mdl[k];
    return r;
  endfunction

  function automatic logic [63:0] mdl_flat();
    logic [63:0] f;
    for (int k = 0; k < 8; k++) f[k*8 +: 8] = mdl[k];
    return f;
  endfunction

  task automatic mdl_clear();
    for (int k = 0; k < 8; k++) mdl[k] = '0;
  endtask

  // Applies one cycle: drive, check pre-edge outputs, clock, update model.
  task automatic step(input mux_sel_t wi, input mux_data_t d, input mux_sel_t ro,
                      input logic t_c, input logic t_d);
    logic [63:0] f;
    en_in  = wi;
    in     = d;
    en_out = ro;
    tc     = t_c;
    td     = t_d;
    #1;
    check_eq("out_pre_edge", out, mdl_read(ro));
    f = mdl_flat();
    check_eq("tq", tq, ScanBuild ? f[63] : 1'b0);
    @(posedge clk);
    if (ScanBuild && t_c) begin
      f = {f[62:0], t_d};
      for (int k = 0; k < 8; k++) mdl[k] = f[k*8 +: 8];
    end else begin
      for (int k = 0; k < 8; k++) if (wi[k]) mdl[k] = d;
    end
    #1;
  endtask

  task automatic probe(input string tag, input mux_sel_t ro, input mux_data_t exp);
    en_in  = '0;
    tc     = 1'b0;
    en_out = ro;
    #1;
    check_eq(tag, out, exp);
  endtask

  initial begin
    logic [63:0] prior;
    mux_sel_t    wi;
    rst_n = 1'b0; in = '0; en_in = '0; en_out = 8'hFF; tc = 1'b0; td = 1'b0;
    mdl_clear();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_out", out, 8'h00);
    check_eq("reset_tq", tq, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Mid-cycle asynchronous reset after filling every register.
    step(8'hFF, 8'hA5, 8'h00, 1'b0, 1'b0);
    probe("fill_a5", 8'h10, 8'hA5);
    #2;
    rst_n = 1'b0;
    mdl_clear();
    for (int k = 0; k < 8; k++) begin
      en_out = mux_sel_t'(1 << k);
      #1;
      check_eq("async_reset_out", out, 8'h00);
    end
    check_eq("async_reset_tq", tq, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write then read.
    step(8'h04, 8'h3C, 8'h04, 1'b0, 1'b0);
    probe("wr_rd_hit", 8'h04, 8'h3C);
    probe("wr_rd_miss", 8'h08, 8'h00);

    // Multi-write and multi-read.
    step(8'h81, 8'h5A, 8'h00, 1'b0, 1'b0);
    probe("multi_wr_r0", 8'h01, 8'h5A);
    probe("multi_wr_r7", 8'h80, 8'h5A);
    step(8'h02, 8'h0F, 8'h00, 1'b0, 1'b0);
    step(8'h04, 8'hF0, 8'h00, 1'b0, 1'b0);
    probe("multi_rd_or", 8'h06, 8'hFF);
    probe("rd_none", 8'h00, 8'h00);

    // Same-cycle read and write: no bypass.
    step(8'h08, 8'h11, 8'h00, 1'b0, 1'b0);
    en_in = 8'h08; in = 8'h22; en_out = 8'h08;
    #1;
    check_eq("rw_same_old", out, 8'h11);
    @(posedge clk);
    mdl[3] = 8'h22;
    #1;
    check_eq("rw_same_new", out, 8'h22);

`ifdef MUX_REG_SCAN_EN
    // 64-bit shift of 1010... with en_in held high; prior contents leave MSB first.
    prior = mdl_flat();
    for (int s = 0; s < 64; s++) begin
      step(8'hFF, 8'hC3, 8'h01, 1'b1, (s % 2 == 0));
      if (s < 63) check_eq("scan_tq_prior", tq, prior[62 - s]);
    end
    for (int k = 0; k < 8; k++) begin
      probe("scan_pattern", mux_sel_t'(1 << k), 8'hAA);
    end
`else
    // Scan controls must be ignored.
    prior = '0;
    step(8'h10, 8'h77, 8'h10, 1'b1, 1'b1);
    probe("noscan_write", 8'h10, 8'h77);
    check_eq("noscan_tq", tq, 1'b0);
    step(8'h00, 8'h00, 8'h10, 1'b1, 1'b0);
    probe("noscan_hold", 8'h10, 8'h77);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 2))
        0:       wi = mux_sel_t'(1 << $urandom_range(0, 7));
        1:       wi = mux_sel_t'($urandom);
        default: wi = '0;
      endcase
      step(wi, mux_data_t'($urandom), mux_sel_t'($urandom),
           ($urandom_range(0, 4) == 0), 1'($urandom));
    end
    for (int k = 0; k < 8; k++) probe("final_reg", mux_sel_t'(1 << k), mdl[k]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_reg_8x8.md
Name: mux_reg_8x8

Overview:
- Bank of DEPTH registers, each WIDTH bits wide.
- Each register is loaded by its own one-hot write-enable bit.
- A single output is selected through an AND-OR mux driven by a one-hot read select.
- Used as a page/bank register slice, e.g. one byte lane of a 32-bit page register, with an optional scan chain for test.

Parameters:
- WIDTH, 8, bits per register.
- DEPTH, 8, number of registers; also the width of EN_IN and EN_OUT.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- IN  input  WIDTH  write data
- EN_IN  input  DEPTH  one-hot write enables; bit k loads register k
- EN_OUT  input  DEPTH  one-hot read select
- OUT  output  WIDTH  selected register contents
- TC  input  1  test control (scan shift enable)
- TD  input  1  scan data in
- TQ  output  1  scan data out

Behaviour:
- Clock and reset: one clock CLK; reset RST_N is asynchronous, active-low.
- Reset:
  - All DEPTH×WIDTH storage bits clear to 0 immediately when RST_N falls, independent of CLK.
  - OUT = 0 and TQ = 0 while reset is held.
  - Release is synchronous-safe: the first write takes effect on the first rising CLK edge after RST_N is high.
- Write:
  - At the rising CLK edge with TC=0, every register k with EN_IN[k]=1 loads IN.
  - Registers with EN_IN[k]=0 hold their value.
  - Several EN_IN bits set: all selected registers load the same IN. EN_IN=0: no change.
- Read:
  - OUT is purely combinational: OUT = OR over k of (EN_OUT[k] ? reg[k] : 0).
  - Zero latency from EN_OUT to OUT. A written value appears on OUT in the cycle after the write edge.
  - EN_OUT=0 gives OUT=0. Multiple EN_OUT bits give the bitwise OR of the selected registers (documented, not an error).
- Simultaneous read and write of the same register: OUT shows the old value until the edge, then the new value. There is no write-through bypass.
- Scan:
  - The chain is reg[0] bit0 → reg[0] bit WIDTH-1 → reg[1] bit0 → … → reg[DEPTH-1] bit WIDTH-1.
  - At the rising edge with TC=1, TD shifts into reg[0] bit0 and every bit moves one position along the chain.
  - TQ = reg[DEPTH-1][WIDTH-1], combinational from the flop.
  - TC=1 overrides EN_IN: no functional writes occur during shift.
  - OUT keeps following EN_OUT during shift.
- Reset during shift or write: reset wins and clears all storage.
- No state machine; storage is DEPTH×WIDTH flops.

Optional Feature:
- Macro: MUX_REG_SCAN_EN.
- Defined: the scan chain is implemented as described above.
- Undefined: TC and TD are ignored, TQ is tied to 0, and writes depend only on EN_IN.
- Functional read/write behaviour is identical in both builds.

Decomposition:
- Package mux_reg_pkg:
  - Constants MUX_REG_WIDTH=8 and MUX_REG_DEPTH=8.
  - Typedefs mux_data_t (logic [WIDTH-1:0]) and mux_sel_t (logic [DEPTH-1:0]).
- Sub-module mux_reg_entry: one WIDTH-bit register with write enable, async active-low clear, and scan in/out, chained DEPTH times in the top level.
- The AND-OR output mux stays in the top level.

Test Plan:
- Reset: write 0xA5 to all registers, pulse RST_N low mid-cycle → OUT=0x00 immediately for every EN_OUT one-hot value, TQ=0.
- Write/read: EN_IN=8'h04 with IN=0x3C, then EN_OUT=8'h04 → OUT=0x3C the next cycle. EN_OUT=8'h08 → OUT=0x00.
- Multi-write / multi-read:
  - EN_IN=8'h81 with IN=0x5A → reg0 and reg7 both equal 0x5A.
  - reg1=0x0F, reg2=0xF0, EN_OUT=8'h06 → OUT=0xFF. EN_OUT=0 → OUT=0.
- Same-cycle read/write: reg3=0x11, EN_OUT=8'h08, EN_IN=8'h08 with IN=0x22 → OUT=0x11 before the edge, 0x22 after it.
- Scan (MUX_REG_SCAN_EN):
  - TC=1, shift 64 bits of pattern 1010… → after 64 edges reg contents match the pattern and TQ has emitted the prior contents MSB-first.
  - EN_IN held at 8'hFF during shift → no functional load.
- Scan disabled build: toggle TC and TD → TQ stays 0 and writes behave normally.
